// File: rtl/breadboard_pkg.sv
// Shared types and frame geometry for the breadboard result serializer.
package breadboard_pkg;

  localparam int FRAME_BITS = 17;
  localparam int DATA_BITS  = FRAME_BITS - 3;
  localparam int RESULT_W   = 10;
  localparam int IDX_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Even parity: the transmitted bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/breadboard_fifo.sv
// Synchronous FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
module breadboard_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/breadboard_frame_tx.sv
// Buffers {r, idx} result words and sends each as a start/14-data/even-parity/stop
// frame on tx, BIT_CYCLES clocks per bit, LSB first.
//
//   state  | meaning
//   IDLE   | line high; pops the head word when one is buffered
//   START  | start bit (low)
//   DATA   | 14 data bits, idx[0] first, r9 last
//   PARITY | even parity over the data bits
//   STOP   | stop bit (high), then back to IDLE
module breadboard_frame_tx
  import breadboard_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IDX_W-1:0]                  in_idx,
  input  logic [RESULT_W-1:0]               in_r,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              drop_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_COUNT = CW'(FIFO_DEPTH);
  localparam logic [7:0]    CYC_LAST    = 8'(BIT_CYCLES - 1);
  localparam logic [3:0]    BIT_LAST    = 4'(DATA_BITS - 1);

  state_t               state;
  state_t               state_next;
  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic [7:0]           cyc;
  logic [3:0]           bit_cnt;
  logic                 bit_end;
  logic                 tx_q;
  logic                 tx_next;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 drop_q;

  assign in_ready = (fifo_count < DEPTH_COUNT);
  assign push     = in_valid & in_ready;
  assign bit_end  = (cyc == CYC_LAST);
  assign busy     = (state != IDLE);
  assign tx       = tx_q;
  assign drop_err = drop_q;

  breadboard_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({in_r, in_idx}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // tx_next is the line level for the current state; registering it keeps tx
  // glitch-free and puts the line one clock behind the state register.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx_next = shreg[0];
        if (bit_end && (bit_cnt == BIT_LAST)) state_next = PARITY;
      end
      PARITY: begin
        tx_next = par_q;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      cyc     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state <= state_next;
      tx_q  <= tx_next;

      if (state_next != state) begin
        cyc <= '0;
      end else if (state != IDLE) begin
        cyc <= bit_end ? 8'd0 : cyc + 8'd1;
      end

      if (state_next != state) begin
        bit_cnt <= '0;
      end else if ((state == DATA) && bit_end) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (pop) begin
        shreg <= head;
        par_q <= even_parity(head);
      end else if ((state == DATA) && bit_end) begin
        shreg <= {1'b0, shreg[DATA_BITS-1:1]};
      end

      if (in_valid && !in_ready) begin
        drop_q <= 1'b1;
      end
    end
  end

endmodule
